// File: rtl/pcpu_if.sv
// Instruction/data memory bus of the pcpu core.
// master = core side, slave = memory side.
interface pcpu_if;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic [7:0]  d_addr;
    logic [15:0] d_datain;
    logic [15:0] d_dataout;
    logic        d_we;

    modport master (
        output i_addr,
        input  i_datain,
        output d_addr,
        input  d_datain,
        output d_dataout,
        output d_we
    );

    modport slave (
        input  i_addr,
        output i_datain,
        input  d_addr,
        output d_datain,
        input  d_dataout,
        input  d_we
    );
endinterface

// File: rtl/pcpu.sv
// 16-bit five-stage (IF/ID/EX/MEM/WB) pipelined core without interlocks, forwarding or flushing.
// Software is responsible for NOP padding around data dependencies and branch shadows.
module pcpu (
    input  logic   clock,
    input  logic   reset,
    input  logic   enable,
    input  logic   start,
    pcpu_if.master bus
);
    localparam logic [4:0] OpNop   = 5'b00000;
    localparam logic [4:0] OpHalt  = 5'b00001;
    localparam logic [4:0] OpLoad  = 5'b00010;
    localparam logic [4:0] OpStore = 5'b00011;
    localparam logic [4:0] OpSll   = 5'b00100;
    localparam logic [4:0] OpSla   = 5'b00101;
    localparam logic [4:0] OpSrl   = 5'b00110;
    localparam logic [4:0] OpSra   = 5'b00111;
    localparam logic [4:0] OpAdd   = 5'b01000;
    localparam logic [4:0] OpAddi  = 5'b01001;
    localparam logic [4:0] OpSub   = 5'b01010;
    localparam logic [4:0] OpSubi  = 5'b01011;
    localparam logic [4:0] OpCmp   = 5'b01100;
    localparam logic [4:0] OpAnd   = 5'b01101;
    localparam logic [4:0] OpOr    = 5'b01110;
    localparam logic [4:0] OpXor   = 5'b01111;
    localparam logic [4:0] OpLdih  = 5'b10000;
    localparam logic [4:0] OpAddc  = 5'b10001;
    localparam logic [4:0] OpSubc  = 5'b10010;
    localparam logic [4:0] OpJump  = 5'b11000;
    localparam logic [4:0] OpJmpr  = 5'b11001;
    localparam logic [4:0] OpBz    = 5'b11010;
    localparam logic [4:0] OpBnz   = 5'b11011;
    localparam logic [4:0] OpBn    = 5'b11100;
    localparam logic [4:0] OpBnn   = 5'b11101;
    localparam logic [4:0] OpBc    = 5'b11110;
    localparam logic [4:0] OpBnc   = 5'b11111;

    typedef enum logic {StIdle, StExec} state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] id_ir_q, id_ir_d;
    // Downstream IR copies keep only the opcode and destination register field.
    logic [15:8] ex_ir_q, ex_ir_d, mem_ir_q, wb_ir_q;
    logic [15:0] reg_a_q, reg_a_d, reg_b_q, reg_b_d;
    logic [15:0] reg_c_q, reg_c1_q, reg_c1_d;
    logic [15:0] smdr_q, smdr_d, smdr1_q;
    logic        zf_q, zf_d, nf_q, nf_d, cf_q, cf_d;
    logic [15:0] gr_q [8];

    logic [4:0]  id_op, ex_op, mem_op, wb_op;
    logic [2:0]  r1, r2, r3;
    logic [7:0]  imm8;
    logic        halt_id, branch_taken, wb_we, cin;
    logic [16:0] add17, sub17;
    logic [15:0] alu_out;
    logic        set_zn, set_c, carry;

    assign id_op  = id_ir_q[15:11];
    assign ex_op  = ex_ir_q[15:11];
    assign mem_op = mem_ir_q[15:11];
    assign wb_op  = wb_ir_q[15:11];
    assign r1     = id_ir_q[10:8];
    assign r2     = id_ir_q[6:4];
    assign r3     = id_ir_q[2:0];
    assign imm8   = id_ir_q[7:0];

    assign halt_id = (state_q == StExec) && (id_op == OpHalt);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StExec;
            StExec:  if (id_op == OpHalt) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (mem_op)
            OpJump, OpJmpr: branch_taken = 1'b1;
            OpBz:           branch_taken = zf_q;
            OpBnz:          branch_taken = !zf_q;
            OpBn:           branch_taken = nf_q;
            OpBnn:          branch_taken = !nf_q;
            OpBc:           branch_taken = cf_q;
            OpBnc:          branch_taken = !cf_q;
            default:        branch_taken = 1'b0;
        endcase
    end

    // IF: a HALT reaching ID stops fetching on the same edge and is itself dropped.
    always_comb begin
        pc_d    = pc_q;
        id_ir_d = {OpNop, 11'b0};
        if (state_q == StExec && !halt_id) begin
            id_ir_d = bus.i_datain;
            pc_d    = branch_taken ? reg_c_q[7:0] : pc_q + 8'd1;
        end
        ex_ir_d = (id_op == OpHalt) ? {OpNop, 3'b0} : id_ir_q[15:8];
    end

    // ID: register read uses the old register file contents (no bypass).
    always_comb begin
        reg_a_d = gr_q[r2];
        reg_b_d = gr_q[r3];
        smdr_d  = gr_q[r1];
        case (id_op)
            OpLoad, OpStore, OpSll, OpSla, OpSrl, OpSra: reg_b_d = {12'h000, id_ir_q[3:0]};
            OpAddi, OpSubi: begin
                reg_a_d = gr_q[r1];
                reg_b_d = {8'h00, imm8};
            end
            OpLdih: begin
                reg_a_d = gr_q[r1];
                reg_b_d = {imm8, 8'h00};
            end
            OpJump: begin
                reg_a_d = 16'h0000;
                reg_b_d = {8'h00, imm8};
            end
            OpJmpr, OpBz, OpBnz, OpBn, OpBnn, OpBc, OpBnc: begin
                reg_a_d = gr_q[r1];
                reg_b_d = {8'h00, imm8};
            end
            default: ;
        endcase
    end

    // EX: cf feeds ADDC/SUBC as carry-in / borrow-in.
    assign cin   = (ex_op == OpAddc || ex_op == OpSubc) ? cf_q : 1'b0;
    assign add17 = {1'b0, reg_a_q} + {1'b0, reg_b_q} + {16'h0000, cin};
    assign sub17 = {1'b0, reg_a_q} - {1'b0, reg_b_q} - {16'h0000, cin};

    always_comb begin
        alu_out = 16'h0000;
        set_zn  = 1'b0;
        set_c   = 1'b0;
        carry   = 1'b0;
        case (ex_op)
            OpAdd, OpAddi, OpAddc, OpLdih: begin
                alu_out = add17[15:0];
                carry   = add17[16];
                set_zn  = 1'b1;
                set_c   = 1'b1;
            end
            OpSub, OpSubi, OpSubc, OpCmp: begin
                alu_out = sub17[15:0];
                carry   = sub17[16];
                set_zn  = 1'b1;
                set_c   = 1'b1;
            end
            OpAnd: begin alu_out = reg_a_q & reg_b_q; set_zn = 1'b1; end
            OpOr:  begin alu_out = reg_a_q | reg_b_q; set_zn = 1'b1; end
            OpXor: begin alu_out = reg_a_q ^ reg_b_q; set_zn = 1'b1; end
            OpSll, OpSla: begin alu_out = reg_a_q << reg_b_q[3:0]; set_zn = 1'b1; end
            OpSrl: begin alu_out = reg_a_q >> reg_b_q[3:0]; set_zn = 1'b1; end
            OpSra: begin
                alu_out = $unsigned($signed(reg_a_q) >>> reg_b_q[3:0]);
                set_zn  = 1'b1;
            end
            OpLoad, OpStore: alu_out = add17[15:0];
            OpJump, OpJmpr, OpBz, OpBnz, OpBn, OpBnn, OpBc, OpBnc:
                alu_out = {8'h00, reg_a_q[7:0] + reg_b_q[7:0]};
            default: alu_out = 16'h0000;
        endcase
        zf_d = set_zn ? (alu_out == 16'h0000) : zf_q;
        nf_d = set_zn ? alu_out[15] : nf_q;
        cf_d = set_c  ? carry : cf_q;
    end

    assign reg_c1_d = (mem_op == OpLoad) ? bus.d_datain : reg_c_q;

    always_comb begin
        case (wb_op)
            OpLoad, OpSll, OpSla, OpSrl, OpSra, OpAdd, OpAddi, OpSub, OpSubi,
            OpAnd, OpOr, OpXor, OpLdih, OpAddc, OpSubc: wb_we = 1'b1;
            default: wb_we = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StIdle;
        end else if (enable) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q     <= 8'h00;
            id_ir_q  <= 16'h0000;
            ex_ir_q  <= 8'h00;
            mem_ir_q <= 8'h00;
            wb_ir_q  <= 8'h00;
            reg_a_q  <= 16'h0000;
            reg_b_q  <= 16'h0000;
            reg_c_q  <= 16'h0000;
            reg_c1_q <= 16'h0000;
            smdr_q   <= 16'h0000;
            smdr1_q  <= 16'h0000;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            cf_q     <= 1'b0;
            for (int i = 0; i < 8; i++) gr_q[i] <= 16'h0000;
        end else if (enable) begin
            pc_q     <= pc_d;
            id_ir_q  <= id_ir_d;
            ex_ir_q  <= ex_ir_d;
            mem_ir_q <= ex_ir_q;
            wb_ir_q  <= mem_ir_q;
            reg_a_q  <= reg_a_d;
            reg_b_q  <= reg_b_d;
            reg_c_q  <= alu_out;
            reg_c1_q <= reg_c1_d;
            smdr_q   <= smdr_d;
            smdr1_q  <= smdr_q;
            zf_q     <= zf_d;
            nf_q     <= nf_d;
            cf_q     <= cf_d;
            if (wb_we) gr_q[wb_ir_q[10:8]] <= reg_c1_q;
        end
    end

    assign bus.i_addr    = pc_q;
    assign bus.d_addr    = reg_c_q[7:0];
    assign bus.d_dataout = smdr1_q;
    assign bus.d_we      = (mem_op == OpStore);
endmodule

// File: tb/tb_pcpu.sv
// Directed bench for pcpu: small programs in a bench-side memory, results observed via
// stores and the fetch address trace.
module tb_pcpu;
    localparam logic [4:0] OpNop   = 5'b00000;
    localparam logic [4:0] OpHalt  = 5'b00001;
    localparam logic [4:0] OpLoad  = 5'b00010;
    localparam logic [4:0] OpStore = 5'b00011;
    localparam logic [4:0] OpSll   = 5'b00100;
    localparam logic [4:0] OpSla   = 5'b00101;
    localparam logic [4:0] OpSrl   = 5'b00110;
    localparam logic [4:0] OpSra   = 5'b00111;
    localparam logic [4:0] OpAdd   = 5'b01000;
    localparam logic [4:0] OpAddi  = 5'b01001;
    localparam logic [4:0] OpSub   = 5'b01010;
    localparam logic [4:0] OpSubi  = 5'b01011;
    localparam logic [4:0] OpCmp   = 5'b01100;
    localparam logic [4:0] OpAnd   = 5'b01101;
    localparam logic [4:0] OpOr    = 5'b01110;
    localparam logic [4:0] OpXor   = 5'b01111;
    localparam logic [4:0] OpLdih  = 5'b10000;
    localparam logic [4:0] OpAddc  = 5'b10001;
    localparam logic [4:0] OpSubc  = 5'b10010;
    localparam logic [4:0] OpJump  = 5'b11000;
    localparam logic [4:0] OpJmpr  = 5'b11001;
    localparam logic [4:0] OpBz    = 5'b11010;
    localparam logic [4:0] OpBnz   = 5'b11011;
    localparam logic [4:0] OpBn    = 5'b11100;
    localparam logic [4:0] OpBnn   = 5'b11101;
    localparam logic [4:0] OpBc    = 5'b11110;
    localparam logic [4:0] OpBnc   = 5'b11111;

    typedef struct packed {
        logic [15:0] pre;
        logic [15:0] br;
        logic        taken;
        logic [7:0]  target;
    } br_case_t;

    logic clock, reset, enable, start;
    pcpu_if bus ();

    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    logic [7:0]  trace [128];
    logic        we_tr [128];
    logic [7:0]  da_tr [128];
    logic [15:0] dd_tr [128];
    br_case_t    cases [14];
    int          tests_run, tests_failed, we_count;

    assign bus.i_datain = imem[bus.i_addr];
    assign bus.d_datain = dmem[bus.d_addr];

    pcpu dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .start  (start),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] rr(input logic [4:0] op, input logic [2:0] a,
                                       input logic [2:0] b, input logic [2:0] c);
        return {op, a, 1'b0, b, 1'b0, c};
    endfunction

    function automatic logic [15:0] rm(input logic [4:0] op, input logic [2:0] a,
                                       input logic [2:0] b, input logic [3:0] v);
        return {op, a, 1'b0, b, v};
    endfunction

    function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] a,
                                       input logic [7:0] imm);
        return {op, a, imm};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
        end
    endtask

    // Memory write happens on the same edge the core sees d_we.
    task automatic tick();
        if (bus.d_we === 1'b1 && enable && reset) begin
            dmem[bus.d_addr] = bus.d_dataout;
            we_count++;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic record(input int k);
        trace[k] = bus.i_addr;
        we_tr[k] = bus.d_we;
        da_tr[k] = bus.d_addr;
        dd_tr[k] = bus.d_dataout;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = {OpNop, 11'b0};
            dmem[i] = 16'hDEAD;
        end
        dmem[0] = 16'h000B;
        dmem[1] = 16'h011B;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        enable = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic start_cpu();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic load_prog_a();
        clear_mem();
        imem[0]  = rm(OpLoad, 1, 0, 0);
        imem[1]  = rm(OpLoad, 2, 0, 1);
        imem[5]  = rr(OpAdd, 3, 1, 2);
        imem[6]  = rr(OpSub, 4, 2, 1);
        imem[7]  = rr(OpAnd, 5, 1, 2);
        imem[8]  = rr(OpOr,  6, 1, 2);
        imem[9]  = rr(OpXor, 7, 1, 2);
        imem[10] = rm(OpStore, 3, 0, 8);
        imem[11] = rm(OpStore, 4, 0, 9);
        imem[12] = rm(OpStore, 5, 0, 10);
        imem[13] = rm(OpStore, 6, 0, 11);
        imem[14] = rm(OpStore, 7, 0, 12);
        imem[15] = rm(OpSll, 3, 1, 4);
        imem[16] = rm(OpSrl, 4, 2, 4);
        imem[17] = ri(OpAddi, 5, 8'hFF);
        imem[18] = ri(OpLdih, 6, 8'h80);
        imem[19] = ri(OpSubi, 7, 8'h11);
        imem[23] = rm(OpStore, 3, 0, 13);
        imem[24] = rm(OpStore, 4, 0, 14);
        imem[25] = rm(OpStore, 5, 0, 15);
        imem[26] = rm(OpStore, 6, 2, 0);
        imem[27] = rm(OpStore, 7, 2, 1);
        imem[28] = rm(OpSra, 3, 6, 4);
        imem[29] = rm(OpSla, 4, 1, 1);
        imem[30] = rr(OpCmp, 0, 1, 2);
        imem[31] = rr(OpSubc, 5, 1, 1);
        imem[32] = rr(OpAddc, 6, 1, 1);
        imem[36] = rm(OpStore, 3, 2, 2);
        imem[37] = rm(OpStore, 4, 2, 3);
        imem[38] = rm(OpStore, 5, 2, 4);
        imem[39] = rm(OpStore, 6, 2, 5);
        imem[40] = {OpHalt, 11'b0};
    endtask

    initial begin
        logic [7:0]  exp_addr [14];
        logic [15:0] exp_data [14];
        logic [7:0]  exp_pc;
        logic [15:0] exp_d8;

        tests_run = 0;
        tests_failed = 0;
        we_count = 0;
        reset = 1'b0;
        enable = 1'b1;
        start = 1'b0;
        clear_mem();

        cases[0]  = '{pre: 16'h0000,          br: ri(OpJump, 0, 8'h0F), taken: 1'b1, target: 8'h0F};
        cases[1]  = '{pre: 16'h0000,          br: ri(OpJmpr, 1, 8'h01), taken: 1'b1, target: 8'h0C};
        cases[2]  = '{pre: rr(OpCmp, 0, 1, 2), br: ri(OpBz,  1, 8'h10), taken: 1'b0, target: 8'h00};
        cases[3]  = '{pre: rr(OpCmp, 0, 1, 2), br: ri(OpBnz, 1, 8'h1F), taken: 1'b1, target: 8'h2A};
        cases[4]  = '{pre: rr(OpCmp, 0, 1, 2), br: ri(OpBn,  1, 8'h3F), taken: 1'b1, target: 8'h4A};
        cases[5]  = '{pre: rr(OpCmp, 0, 1, 2), br: ri(OpBnn, 1, 8'h10), taken: 1'b0, target: 8'h00};
        cases[6]  = '{pre: rr(OpCmp, 0, 1, 2), br: ri(OpBc,  1, 8'hFF), taken: 1'b1, target: 8'h0A};
        cases[7]  = '{pre: rr(OpCmp, 0, 1, 2), br: ri(OpBnc, 1, 8'h10), taken: 1'b0, target: 8'h00};
        cases[8]  = '{pre: rr(OpCmp, 0, 1, 1), br: ri(OpBz,  1, 8'h3F), taken: 1'b1, target: 8'h4A};
        cases[9]  = '{pre: rr(OpCmp, 0, 1, 1), br: ri(OpBnn, 1, 8'h07), taken: 1'b1, target: 8'h12};
        cases[10] = '{pre: rr(OpCmp, 0, 1, 1), br: ri(OpBnc, 1, 8'h01), taken: 1'b1, target: 8'h0C};
        cases[11] = '{pre: rr(OpCmp, 0, 1, 1), br: ri(OpBnz, 1, 8'h10), taken: 1'b0, target: 8'h00};
        cases[12] = '{pre: rr(OpCmp, 0, 1, 1), br: ri(OpBn,  1, 8'h10), taken: 1'b0, target: 8'h00};
        cases[13] = '{pre: rr(OpCmp, 0, 1, 1), br: ri(OpBc,  1, 8'h10), taken: 1'b0, target: 8'h00};

        exp_addr = '{8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F,
                     8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F, 8'h20};
        exp_data = '{16'h0126, 16'h0110, 16'h000B, 16'h011B, 16'h0110, 16'h00B0, 16'h0011,
                     16'h010A, 16'h811B, 16'h00FF, 16'hF811, 16'h0016, 16'hFFFF, 16'h0017};

        // Power-on reset
        tick();
        tick();
        check("rst i_addr", 16'(bus.i_addr), 16'h0000);
        check("rst d_addr", 16'(bus.d_addr), 16'h0000);
        check("rst d_dataout", bus.d_dataout, 16'h0000);
        check("rst d_we", 16'(bus.d_we), 16'h0000);
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("idle pc hold", 16'(bus.i_addr), 16'h0000);

        // Program A: ALU/shift/immediate/carry ops, with a 3-cycle enable stall on a store
        load_prog_a();
        we_count = 0;
        start_cpu();
        for (int k = 0; k < 80; k++) begin
            record(k);
            if (k == 26) enable = 1'b0;
            if (k == 29) begin
                check("stall i_addr", 16'(bus.i_addr), 16'd26);
                check("stall d_we", 16'(bus.d_we), 16'h0001);
                check("stall d_addr", 16'(bus.d_addr), 16'h000D);
                check("stall d_dataout", bus.d_dataout, 16'h00B0);
                enable = 1'b1;
            end
            tick();
        end
        for (int k = 0; k < 4; k++) check($sformatf("fetch seq %0d", k), 16'(trace[k]), 16'(k));
        check("pc after stall", 16'(trace[30]), 16'd27);
        for (int i = 0; i < 14; i++)
            check($sformatf("progA mem[%02h]", exp_addr[i]), dmem[exp_addr[i]], exp_data[i]);
        check("store count", 16'(we_count), 16'd14);
        check("halt pc", 16'(bus.i_addr), 16'd41);
        tick();
        tick();
        check("halt pc frozen", 16'(bus.i_addr), 16'd41);
        check("halt drained d_we", 16'(bus.d_we), 16'h0000);

        // Reset in the middle of program A, with enable low (reset must still win)
        load_prog_a();
        apply_reset();
        start_cpu();
        for (int k = 0; k < 14; k++) begin
            record(k);
            if (k < 13) tick();
        end
        check("mid d_we pre", 16'(we_tr[12]), 16'h0000);
        check("mid d_we", 16'(we_tr[13]), 16'h0001);
        check("mid d_addr", 16'(da_tr[13]), 16'h0008);
        check("mid d_dataout", dd_tr[13], 16'h0126);
        reset = 1'b0;
        enable = 1'b0;
        tick();
        check("abort i_addr", 16'(bus.i_addr), 16'h0000);
        check("abort d_addr", 16'(bus.d_addr), 16'h0000);
        check("abort d_dataout", bus.d_dataout, 16'h0000);
        check("abort d_we", 16'(bus.d_we), 16'h0000);

        // Program B: every general register reads zero after reset
        clear_mem();
        for (int r = 1; r < 8; r++) imem[r - 1] = rm(OpStore, 3'(r), 0, 4'(r));
        imem[7] = {OpHalt, 11'b0};
        apply_reset();
        start_cpu();
        for (int k = 0; k < 20; k++) tick();
        for (int r = 1; r < 8; r++) check($sformatf("rst gr%0d", r), dmem[r], 16'h0000);

        // Branch scenarios: gr1=0x000B, gr2=0x011B; branch at 6, shadow 7..9, probe at 10
        for (int s = 0; s < 14; s++) begin
            clear_mem();
            imem[0]  = rm(OpLoad, 1, 0, 0);
            imem[1]  = rm(OpLoad, 2, 0, 1);
            imem[5]  = cases[s].pre;
            imem[6]  = cases[s].br;
            imem[7]  = rm(OpStore, 1, 0, 3);
            imem[10] = rm(OpStore, 2, 0, 8);
            apply_reset();
            start_cpu();
            for (int k = 0; k < 16; k++) begin
                record(k);
                tick();
            end
            exp_pc = cases[s].taken ? cases[s].target : 8'd10;
            exp_d8 = (!cases[s].taken || cases[s].target == 8'd10) ? 16'h011B : 16'hDEAD;
            check($sformatf("br%0d shadow fetch", s), 16'(trace[9]), 16'd9);
            check($sformatf("br%0d next pc", s), 16'(trace[10]), 16'(exp_pc));
            check($sformatf("br%0d shadow store", s), dmem[3], 16'h000B);
            check($sformatf("br%0d fallthrough", s), dmem[8], exp_d8);
            if (s == 0) begin
                check("st d_we before", 16'(we_tr[9]), 16'h0000);
                check("st d_we", 16'(we_tr[10]), 16'h0001);
                check("st d_addr", 16'(da_tr[10]), 16'h0003);
                check("st d_dataout", dd_tr[10], 16'h000B);
                check("st d_we after", 16'(we_tr[11]), 16'h0000);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pcpu.md
# pcpu

`pcpu` is a 16-bit, five-stage pipelined processor core (IF, ID, EX, MEM, WB) with eight 16-bit general registers `gr0`–`gr7` and zero, negative and carry flags. It has separate 8-bit-addressed instruction and data ports, and the testbench or system memory drives both. There are no hazard interlocks, no forwarding and no branch flushing; software inserts NOPs where needed.

## Interface
- No parameters.
- `clock` in 1: sole clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; clears all state.
- `enable` in 1: 1 = run; 0 = freeze all registers, FSM included.
- `start` in 1: pulse that moves the FSM from idle to exec.
- `i_datain` in 16: instruction at `i_addr`, combinational.
- `d_datain` in 16: data at `d_addr`, combinational.
- `i_addr` out 8: equals `pc`.
- `d_addr` out 8: `reg_C[7:0]` of the instruction in MEM.
- `d_dataout` out 16: store data of the instruction in MEM.
- `d_we` out 1: high while a STORE is in MEM.

## Operation
- Instruction layout: `op`=[15:11], `r1`=[10:8], `r2`=[6:4], `r3`=[2:0], `val3`=[3:0], `imm8`=[7:0]. Bits 7 and 3 are ignored when they are register fields.
- Opcodes:
  - NOP 00000, HALT 00001.
  - LOAD 00010, STORE 00011.
  - SLL 00100, SLA 00101, SRL 00110, SRA 00111.
  - ADD 01000, ADDI 01001, SUB 01010, SUBI 01011, CMP 01100.
  - AND 01101, OR 01110, XOR 01111.
  - LDIH 10000, ADDC 10001, SUBC 10010.
  - JUMP 11000, JMPR 11001, BZ 11010, BNZ 11011, BN 11100, BNN 11101, BC 11110, BNC 11111.
  - Any other opcode behaves as NOP.
- Register-register ALU ops: `gr[r1] = gr[r2] op gr[r3]`.
- ADDC/SUBC additionally add `cf` (ADDC) or subtract `cf` (SUBC).
- CMP computes `gr[r2]-gr[r3]`, updates flags only and writes no register.
- ADDI/SUBI: `gr[r1] = gr[r1] ± {8'b0,imm8}`.
- LDIH: `gr[r1] = gr[r1] + {imm8,8'b0}`.
- Shifts: `gr[r1] = gr[r2]` shifted by `val3`.
  - SLL and SLA shift left, zero fill.
  - SRL shifts right, zero fill.
  - SRA shifts right, sign fill.
- LOAD: `gr[r1] = mem[gr[r2]+val3]`.
- STORE: `mem[gr[r2]+val3] = gr[r1]`.
- Address arithmetic is 16-bit; only bits [7:0] drive `d_addr`.
- Flags:
  - ADD, ADDI, ADDC, SUB, SUBI, SUBC, CMP and LDIH set `zf` (result==0), `nf` (result[15]) and `cf` (carry out, or borrow for subtract).
  - Logic ops and shifts set `zf` and `nf`; `cf` is unchanged.
  - All other instructions leave the flags unchanged.
- Branch targets, computed in EX into `reg_C` (8-bit wrap):
  - JUMP: `imm8`.
  - JMPR and the conditional branches: `gr[r1][7:0]+imm8`.
- Branch conditions: BZ `zf`, BNZ `!zf`, BN `nf`, BNN `!nf`, BC `cf`, BNC `!cf`. They are evaluated on the flags as updated by the immediately preceding instruction's EX.
- Branch effect: when a taken branch is in MEM, the next `pc` equals `reg_C[7:0]`; otherwise `pc+1`.
  - Instructions already fetched behind a branch are not flushed; they execute normally.
- Register file: written at the WB edge and read in ID from the old value. There is no bypass.
- FSM has two states:
  - idle: `pc` holds and IF inserts NOP into `id_ir`; downstream stages drain.
  - exec: normal fetch/execute.
  - Transitions: idle→exec when `start`=1. exec→idle when HALT reaches ID; the HALT itself is then replaced by NOP.
- Pipeline registers:
  - `id_ir`.
  - EX operands `reg_A` and `reg_B`.
  - `reg_C`: ALU result or address, in MEM.
  - `reg_C1`: WB data, either `d_datain` for LOAD or `reg_C`.
  - Each stage also carries its own IR copy downstream.

## Timing
- All transitions occur on the `clock` rising edge.
- `reset`=0 sampled at an edge clears `pc`, all IRs, `reg_A`, `reg_B`, `reg_C`, `reg_C1`, `gr0`–`gr7` and all flags, and sets FSM to idle.
  - After reset, `i_addr`=0, `d_addr`=0, `d_dataout`=0 and `d_we`=0.
- `reset` has priority over `enable`. Reset asserted mid-program aborts all in-flight instructions.
- Latency per stage:
  - Instruction at `i_addr` during cycle n is in ID in cycle n+1, EX in n+2, MEM in n+3 and WB in n+4.
  - `gr` is updated at the end of n+4.
- A consumer in ID at n+5 or later sees the new value. Three NOPs between dependent instructions are required.
- Branch shadow: the 3 instructions after a branch always execute, and the target is fetched in cycle n+4.
- `enable`=0 freezes every register for that cycle, including FSM; outputs hold.

## Test plan
- Reset and start:
  - Hold `reset`=0 for 1 edge → all outputs 0 and all `gr`=0.
  - Release reset, then pulse `start` → `i_addr` increments 0,1,2,… each cycle.
- LOAD:
  - LOAD gr1,[gr0+0] with `d_datain`=0x000B while it is in MEM → `gr1`=0x000B after WB.
  - LOAD gr2 with `d_datain`=0x011B → `gr2`=0x011B.
- Jumps:
  - JUMP 0x0F → `pc`=0x0F when it is in MEM.
  - JMPR gr1,0x01 with `gr1`=0x0B → `pc`=0x0C.
- CMP gr1,gr2 (0x000B vs 0x011B) → `nf`=1, `cf`=1, `zf`=0.
  - Following BZ: not taken.
  - BNZ +0x1F → target 0x2A.
  - BN +0x3F → target 0x4A.
  - BNN: not taken.
  - BC +0xFF → target 0x0A (8-bit wrap).
  - BNC: not taken.
- CMP gr1,gr1 → `zf`=1, `nf`=0, `cf`=0.
  - Following BZ +0x3F → target 0x4A.
  - BNN +7 → target 0x12.
  - BNC +1 → target 0x0C.
  - BNZ, BN and BC are not taken.
- STORE and HALT:
  - STORE gr1,[gr0+3] → `d_we`=1, `d_addr`=0x03 and `d_dataout`=`gr1` for exactly one cycle.
  - HALT → `pc` freezes and the pipeline drains.
  - `enable`=0 mid-program → all state holds.
